// File: rtl/i2c_debug_target_if.sv
// Pin-level and debug-window signals shared between the I2C debug target
// and the chip top level (or a bench acting as controller and top level).
interface i2c_debug_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [3:0] reg_idx;
    logic [7:0] reg_data;
    logic [7:0] ctrl;
    logic       busy;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  reg_data,
        output sda_oe,
        output reg_idx,
        output ctrl,
        output busy
    );

    modport master (
        output scl_in,
        output sda_in,
        output reg_data,
        input  sda_oe,
        input  reg_idx,
        input  ctrl,
        input  busy
    );
endinterface

// File: rtl/i2c_debug_target.sv
// I2C target exposing a 16-entry debug byte window plus one writable control
// register at index 4'hF. SCL/SDA are oversampled on cpu_clk.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | bus idle or reset, waiting for START
// S_ADDR     | shifting in address byte
// S_ADDR_ACK | ACKing our address, then entering write or read
// S_WR_DATA  | shifting in a write byte (pointer first, then data)
// S_WR_ACK   | ACKing a write byte
// S_RD_DATA  | driving a read byte, MSB first
// S_RD_ACK   | waiting for controller ACK/NACK
// S_IGNORE   | not addressed or NACKed, SDA released until START/STOP
module i2c_debug_target #(
    parameter logic [6:0] ADDR = 7'h2A
) (
    input  logic              cpu_clk,
    input  logic              rst,
    i2c_debug_target_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_scl_s1, r_scl_s2, r_scl_h;
    logic       r_sda_s1, r_sda_s2, r_sda_h;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_ack_drv, w_ack_drv_nxt;
    logic       r_ptr_loaded, w_ptr_loaded_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [3:0] r_reg_idx, w_reg_idx_nxt;
    logic [7:0] r_ctrl, w_ctrl_nxt;
    logic       r_busy, w_busy_nxt;

    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0] w_byte, w_load;

    // Synchronizers and history flops; reset to the idle-high bus level so
    // leaving reset never fakes an edge.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
        end else begin
            r_scl_s1 <= bus.scl_in; r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
            r_sda_s1 <= bus.sda_in; r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
    assign w_byte     = {r_shift[6:0], r_sda_s2};
    assign w_load     = (r_reg_idx == 4'hF) ? r_ctrl : bus.reg_data;

    // State and datapath registers; reset releases SDA immediately.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_rw         <= 1'b0;
            r_ack_drv    <= 1'b0;
            r_ptr_loaded <= 1'b0;
            r_sda_oe     <= 1'b0;
            r_reg_idx    <= 4'h0;
            r_ctrl       <= 8'h00;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_rw         <= w_rw_nxt;
            r_ack_drv    <= w_ack_drv_nxt;
            r_ptr_loaded <= w_ptr_loaded_nxt;
            r_sda_oe     <= w_sda_oe_nxt;
            r_reg_idx    <= w_reg_idx_nxt;
            r_ctrl       <= w_ctrl_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state decode; START/STOP override any coincident SCL edge.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = S_ADDR;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:     if (w_scl_rise && r_bit_cnt == 3'd7)
                                w_state_nxt = (w_byte[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: if (w_scl_fall && r_ack_drv)
                                w_state_nxt = r_rw ? S_RD_DATA : S_WR_DATA;
                S_WR_DATA:  if (w_scl_rise && r_bit_cnt == 3'd7) w_state_nxt = S_WR_ACK;
                S_WR_ACK:   if (w_scl_fall && r_ack_drv) w_state_nxt = S_WR_DATA;
                S_RD_DATA:  if (w_scl_fall && r_bit_cnt == 3'd7) w_state_nxt = S_RD_ACK;
                S_RD_ACK:   if (w_scl_rise && r_sda_s2) w_state_nxt = S_IGNORE;
                            else if (w_scl_fall) w_state_nxt = S_RD_DATA;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    // Datapath and output updates; SDA only moves on SCL fall, START or STOP.
    always_comb begin
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_rw_nxt         = r_rw;
        w_ack_drv_nxt    = r_ack_drv;
        w_ptr_loaded_nxt = r_ptr_loaded;
        w_sda_oe_nxt     = r_sda_oe;
        w_reg_idx_nxt    = r_reg_idx;
        w_ctrl_nxt       = r_ctrl;
        if (w_start) begin
            w_bit_cnt_nxt    = 3'd0;
            w_ptr_loaded_nxt = 1'b0;
            w_sda_oe_nxt     = 1'b0;
            w_ack_drv_nxt    = 1'b0;
        end else if (w_stop) begin
            w_sda_oe_nxt  = 1'b0;
            w_ack_drv_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: if (w_scl_rise) begin
                    w_shift_nxt   = w_byte;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_rw_nxt      = r_sda_s2;
                        w_ack_drv_nxt = 1'b0;
                    end
                end
                S_ADDR_ACK: if (w_scl_fall) begin
                    w_bit_cnt_nxt = 3'd0;
                    if (!r_ack_drv) begin
                        w_sda_oe_nxt  = 1'b1;
                        w_ack_drv_nxt = 1'b1;
                    end else if (r_rw) begin
                        w_shift_nxt  = w_load;
                        w_sda_oe_nxt = ~w_load[7];
                    end else begin
                        w_sda_oe_nxt = 1'b0;
                    end
                end
                S_WR_DATA: if (w_scl_rise) begin
                    w_shift_nxt   = w_byte;
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_ack_drv_nxt = 1'b0;
                        if (!r_ptr_loaded) begin
                            w_reg_idx_nxt    = w_byte[3:0];
                            w_ptr_loaded_nxt = 1'b1;
                        end else begin
                            if (r_reg_idx == 4'hF) w_ctrl_nxt = w_byte;
                            w_reg_idx_nxt = r_reg_idx + 4'd1;
                        end
                    end
                end
                S_WR_ACK: if (w_scl_fall) begin
                    if (!r_ack_drv) begin
                        w_sda_oe_nxt  = 1'b1;
                        w_ack_drv_nxt = 1'b1;
                    end else begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 3'd0;
                    end
                end
                S_RD_DATA: if (w_scl_fall) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_reg_idx_nxt = r_reg_idx + 4'd1;
                        w_bit_cnt_nxt = 3'd0;
                    end else begin
                        w_shift_nxt   = {r_shift[6:0], 1'b0};
                        w_sda_oe_nxt  = ~r_shift[6];
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
                S_RD_ACK: if (w_scl_fall) begin
                    // A NACK has already left via the rising edge.
                    w_shift_nxt   = w_load;
                    w_sda_oe_nxt  = ~w_load[7];
                    w_bit_cnt_nxt = 3'd0;
                end
                default: w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    // busy follows the addressed-transaction states, registered with them.
    always_comb begin
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK: w_busy_nxt = 1'b1;
            default: w_busy_nxt = 1'b0;
        endcase
    end

    assign bus.sda_oe  = r_sda_oe;
    assign bus.reg_idx = r_reg_idx;
    assign bus.ctrl    = r_ctrl;
    assign bus.busy    = r_busy;

endmodule

// File: tb/tb_i2c_debug_target.sv
// Directed bench: acts as I2C controller and as the top level that supplies
// reg_data = reg_idx * 8'h11 and resolves the open-drain SDA line.
module tb_i2c_debug_target;

    localparam int HP = 240;

    logic cpu_clk = 1'b0;
    logic rst = 1'b0;
    logic r_scl_m = 1'b1;
    logic r_sda_m = 1'b1;
    logic mon_en = 1'b0;
    logic saw_oe = 1'b0;
    int   total = 0;
    int   bad = 0;

    i2c_debug_target_if bus ();

    assign bus.scl_in   = r_scl_m;
    assign bus.sda_in   = r_sda_m & ~bus.sda_oe;
    assign bus.reg_data = {bus.reg_idx, bus.reg_idx};

    i2c_debug_target #(.ADDR(7'h2A)) dut (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #5 cpu_clk = ~cpu_clk;

    always @(negedge cpu_clk) if (mon_en && bus.sda_oe === 1'b1) saw_oe = 1'b1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic bit_out(input logic b);
        #(HP/2) r_sda_m = b;
        #(HP/2) r_scl_m = 1'b1;
        #HP     r_scl_m = 1'b0;
    endtask

    task automatic bit_in(output logic b);
        #(HP/2) r_sda_m = 1'b1;
        #(HP/2) r_scl_m = 1'b1;
        #(HP/2) b = bus.sda_in;
        #(HP/2) r_scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        #(HP/2) r_sda_m = 1'b1;
        #(HP/2) r_scl_m = 1'b1;
        #HP     r_sda_m = 1'b0;
        #HP     r_scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        #(HP/2) r_sda_m = 1'b0;
        #(HP/2) r_scl_m = 1'b1;
        #HP     r_sda_m = 1'b1;
        #HP;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic nack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        bit_in(nack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bit_in(b);
            d = {d[6:0], b};
        end
        bit_out(nack);
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
        total++; if (bus.ctrl !== 8'h00) begin bad++; $display("FAIL reset_ctrl: got %h want 00", bus.ctrl); end
        total++; if (bus.reg_idx !== 4'h0) begin bad++; $display("FAIL reset_idx: got %h want 0", bus.reg_idx); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        #19 rst = 1'b0;
        #20;
    endtask

    task automatic test_write_ctrl();
        logic n0, n1, n2;
        i2c_start();
        send_byte(8'h54, n0);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b want 1", bus.busy); end
        send_byte(8'h0F, n1);
        for (int i = 7; i >= 0; i--) bit_out(i[0] ? ((8'hA5 >> i) & 1) != 0 : ((8'hA5 >> i) & 1) != 0);
        total++; if (bus.ctrl !== 8'hA5) begin bad++; $display("FAIL wr_ctrl_at_bit8: got %h want a5", bus.ctrl); end
        bit_in(n2);
        total++; if ({n0, n1, n2} !== 3'b000) begin bad++; $display("FAIL wr_acks: got %b want 000", {n0, n1, n2}); end
        i2c_stop();
        total++; if (bus.reg_idx !== 4'h0) begin bad++; $display("FAIL wr_idx_wrap: got %h want 0", bus.reg_idx); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop: got %b want 0", bus.busy); end
    endtask

    task automatic test_read_seq();
        logic n0, n1, n2;
        logic [7:0] d0, d1, d2;
        i2c_start();
        send_byte(8'h54, n0);
        send_byte(8'h03, n1);
        i2c_start();
        send_byte(8'h55, n2);
        total++; if ({n0, n1, n2} !== 3'b000) begin bad++; $display("FAIL rd_acks: got %b want 000", {n0, n1, n2}); end
        recv_byte(d0, 1'b0);
        recv_byte(d1, 1'b0);
        recv_byte(d2, 1'b1);
        total++; if (d0 !== 8'h33) begin bad++; $display("FAIL rd_byte0: got %h want 33", d0); end
        total++; if (d1 !== 8'h44) begin bad++; $display("FAIL rd_byte1: got %h want 44", d1); end
        total++; if (d2 !== 8'h55) begin bad++; $display("FAIL rd_byte2: got %h want 55", d2); end
        total++; if (bus.reg_idx !== 4'h6) begin bad++; $display("FAIL rd_idx: got %h want 6", bus.reg_idx); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rd_busy_after_nack: got %b want 0", bus.busy); end
        total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL rd_sda_released: got %b want 0", bus.sda_oe); end
        i2c_stop();
    endtask

    task automatic test_mismatch();
        logic n0, n1, n2;
        logic [7:0] ctrl0;
        logic [3:0] idx0;
        ctrl0 = bus.ctrl;
        idx0  = bus.reg_idx;
        saw_oe = 1'b0;
        mon_en = 1'b1;
        i2c_start();
        send_byte(8'h44, n0);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mis_busy: got %b want 0", bus.busy); end
        send_byte(8'h0F, n1);
        send_byte(8'h77, n2);
        i2c_stop();
        mon_en = 1'b0;
        total++; if (saw_oe !== 1'b0) begin bad++; $display("FAIL mis_sda_oe_seen: got %b want 0", saw_oe); end
        total++; if ({n0, n1, n2} !== 3'b111) begin bad++; $display("FAIL mis_nacks: got %b want 111", {n0, n1, n2}); end
        total++; if (bus.ctrl !== 8'hA5) begin bad++; $display("FAIL mis_ctrl: got %h want a5", bus.ctrl); end
        total++; if (bus.ctrl !== ctrl0) begin bad++; $display("FAIL mis_ctrl_kept: got %h want %h", bus.ctrl, ctrl0); end
        total++; if (bus.reg_idx !== idx0) begin bad++; $display("FAIL mis_idx_kept: got %h want %h", bus.reg_idx, idx0); end
    endtask

    task automatic test_read_ctrl();
        logic n0, n1, n2;
        logic [7:0] d0, d1;
        i2c_start();
        send_byte(8'h54, n0);
        send_byte(8'h0F, n1);
        i2c_start();
        send_byte(8'h55, n2);
        recv_byte(d0, 1'b0);
        recv_byte(d1, 1'b1);
        i2c_stop();
        total++; if ({n0, n1, n2} !== 3'b000) begin bad++; $display("FAIL rc_acks: got %b want 000", {n0, n1, n2}); end
        total++; if (d0 !== 8'hA5) begin bad++; $display("FAIL rc_byte0: got %h want a5", d0); end
        total++; if (d1 !== 8'h00) begin bad++; $display("FAIL rc_byte1: got %h want 00", d1); end
        total++; if (bus.reg_idx !== 4'h1) begin bad++; $display("FAIL rc_idx: got %h want 1", bus.reg_idx); end
    endtask

    task automatic test_reset_mid_read();
        logic n0, n1, n2, b;
        i2c_start();
        send_byte(8'h54, n0);
        send_byte(8'h03, n1);
        i2c_start();
        send_byte(8'h55, n2);
        for (int i = 0; i < 4; i++) bit_in(b);
        #(HP/2);
        total++; if (bus.sda_oe !== 1'b1) begin bad++; $display("FAIL mr_bit3_driven: got %b want 1", bus.sda_oe); end
        #1 rst = 1'b1;
        #1;
        total++; if (bus.sda_oe !== 1'b0) begin bad++; $display("FAIL mr_async_release: got %b want 0", bus.sda_oe); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mr_busy: got %b want 0", bus.busy); end
        #4 rst = 1'b0;
        #4;
        #110 r_sda_m = 1'b1;
        #(HP/2) r_scl_m = 1'b1;
        #HP;
        i2c_start();
        send_byte(8'h54, n0);
        send_byte(8'h0F, n1);
        send_byte(8'h3C, n2);
        i2c_stop();
        total++; if ({n0, n1, n2} !== 3'b000) begin bad++; $display("FAIL mr_rewrite_acks: got %b want 000", {n0, n1, n2}); end
        total++; if (bus.ctrl !== 8'h3C) begin bad++; $display("FAIL mr_ctrl: got %h want 3c", bus.ctrl); end
    endtask

    initial begin
        test_reset();
        test_write_ctrl();
        test_read_seq();
        test_mismatch();
        test_read_ctrl();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
